muldiv_controller: RTL

Sequencing controller for the iterative multiply/divide unit and its HI/LO registers. It accepts a MULT/MULTU/DIV/DIVU issue from the execute stage and runs a 32-step radix-2 shift-add or restoring-divide datapath. It then applies sign correction and commits HI/LO. While busy, it raises a stall request that the pipeline ORs into the f_stall/d_stall/e_flush path, so that any decode-stage HI/LO consumer freezes until results are valid.

---
 rtl/muldiv_controller_pkg.sv | 38 +++
 rtl/muldiv_controller_step.sv | 33 +++
 rtl/muldiv_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/muldiv_controller_pkg.sv
// Shared types and sizing for the iterative multiply/divide controller.
package muldiv_controller_pkg;

  localparam int unsigned MD_ITERATIONS = 32;
  localparam int unsigned MD_W          = 32;
  localparam int unsigned MD_ACC_W      = 2 * MD_W;
  localparam int unsigned MD_CNT_W      = $clog2(MD_ITERATIONS);

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Per-operation context captured at issue and consumed by the correction step.
  typedef struct packed {
    md_op_t op;
    logic   sign_a;
    logic   sign_b;
    logic   div_zero;
  } md_ctx_t;

  function automatic logic md_is_signed(md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_controller_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_controller_pkg::*;
(
  input  logic [MD_ACC_W-1:0] acc,
  input  logic [MD_W-1:0]     opr,
  input  logic [MD_W-1:0]     opb,
  input  logic                is_div,
  output logic [MD_ACC_W-1:0] acc_nxt_c,
  output logic [MD_W-1:0]     opr_nxt_c
);

  logic [MD_W:0]   part_rem;
  logic [MD_W:0]   diff;
  logic            fits;
  logic [MD_W-1:0] new_rem;

  // Divide keeps {remainder, quotient} in acc; remainder stays below the divisor so it fits 32 bits.
  always_comb begin
    part_rem  = {acc[MD_ACC_W-1:MD_W], opr[MD_W-1]};
    diff      = part_rem - {1'b0, opb};
    fits      = (part_rem >= {1'b0, opb});
    new_rem   = fits ? diff[MD_W-1:0] : part_rem[MD_W-1:0];
    opr_nxt_c = {opr[MD_W-2:0], 1'b0};
    if (is_div) begin
      acc_nxt_c = {new_rem, acc[MD_W-2:0], fits};
    end else begin
      acc_nxt_c = {acc[MD_ACC_W-2:0], 1'b0}
                + (opr[MD_W-1] ? {{MD_W{1'b0}}, opb} : {MD_ACC_W{1'b0}});
    end
  end

endmodule

// File: rtl/muldiv_controller.sv
// Sequences the iterative mul/div datapath, applies sign correction and owns HI/LO.
module muldiv_controller
  import muldiv_controller_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            e_md_start,
  input  logic [1:0]      e_md_op,
  input  logic [MD_W-1:0] e_rd0,
  input  logic [MD_W-1:0] e_rd1,
  input  logic            e_flush,
  input  logic            d_hilo_use,
  input  logic            w_hi_we,
  input  logic            w_lo_we,
  input  logic [MD_W-1:0] w_hilo_wd,
  output logic            md_busy,
  output logic            md_stall,
  output logic            md_done,
  output logic [MD_W-1:0] hi,
  output logic [MD_W-1:0] lo
);

  md_state_t             state, state_next;
  md_ctx_t               ctx;
  logic [MD_CNT_W-1:0]   cnt;
  logic [MD_ACC_W-1:0]   acc, acc_nxt, prod;
  logic [MD_W-1:0]       opr, opr_nxt, opb;
  logic [MD_W-1:0]       mag_a, mag_b, quo, rem, fix_hi, fix_lo;
  md_op_t                start_op;
  logic                  go, neg_a, neg_b;

  assign start_op = md_op_t'(e_md_op);
  assign go       = e_md_start & ~e_flush;
  assign neg_a    = md_is_signed(start_op) & e_rd0[MD_W-1];
  assign neg_b    = md_is_signed(start_op) & e_rd1[MD_W-1];
  assign mag_a    = neg_a ? -e_rd0 : e_rd0;
  assign mag_b    = neg_b ? -e_rd1 : e_rd1;

  assign md_busy  = (state != IDLE);
  assign md_stall = d_hilo_use & (md_busy | go);

  muldiv_step u_step (
    .acc       (acc),
    .opr       (opr),
    .opb       (opb),
    .is_div    (md_is_div(ctx.op)),
    .acc_nxt_c (acc_nxt),
    .opr_nxt_c (opr_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = RUN;
      RUN:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction; a zero divisor leaves the all-ones quotient and the dividend as remainder.
  always_comb begin
    prod   = acc;
    quo    = acc[MD_W-1:0];
    rem    = acc[MD_ACC_W-1:MD_W];
    fix_hi = rem;
    fix_lo = quo;
    if (!md_is_div(ctx.op)) begin
      if ((ctx.op == MD_MULT) && (ctx.sign_a ^ ctx.sign_b)) prod = -acc;
      fix_hi = prod[MD_ACC_W-1:MD_W];
      fix_lo = prod[MD_W-1:0];
    end else begin
      if ((ctx.op == MD_DIV) && ctx.sign_a) fix_hi = -rem;
      if (ctx.div_zero) fix_lo = '1;
      else if ((ctx.op == MD_DIV) && (ctx.sign_a ^ ctx.sign_b)) fix_lo = -quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctx     <= '0;
      cnt     <= '0;
      acc     <= '0;
      opr     <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= (state == FIX);
      case (state)
        IDLE: begin
          if (go) begin
            ctx.op       <= start_op;
            ctx.sign_a   <= neg_a;
            ctx.sign_b   <= neg_b;
            ctx.div_zero <= md_is_div(start_op) && (e_rd1 == '0);
            opr          <= md_is_div(start_op) ? mag_a : mag_b;
            opb          <= md_is_div(start_op) ? mag_b : mag_a;
            cnt          <= MD_CNT_W'(MD_ITERATIONS - 1);
            acc          <= '0;
          end else begin
            if (w_hi_we) hi <= w_hilo_wd;
            if (w_lo_we) lo <= w_hilo_wd;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          opr <= opr_nxt;
          if (cnt != '0) cnt <= cnt - MD_CNT_W'(1);
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule
